// File: rtl/hplvds_pkg.sv
// hplvds_pkg: shared FSM states and constants for the HPLVDS lane receiver.
package hplvds_pkg;
    typedef enum logic [2:0] {OFF, SETTLE, IDLE, HUNT, LOCKED} state_e;
    localparam logic [7:0] SYNC_WORD_DEF = 8'hBC;
    // Tap mask of x^7+x^6+1 over a history register whose bit 0 is the newest bit
    localparam logic [6:0] PRBS7_POLY = 7'h60;
endpackage

// File: rtl/hplvds_ei_debounce.sv
// hplvds_ei_debounce: electrical-idle debouncer; output flips only after the
// input holds the opposite level for EI_DEB_CYC consecutive cycles.
module hplvds_ei_debounce #(
    parameter int unsigned EI_DEB_CYC = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic set_i,
    input  logic ei_detect_i,
    output logic ei_o,
    output logic rise_o
);
    localparam int CW = $clog2(EI_DEB_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic ei_q;
    logic flip_d;
    assign flip_d = (ei_detect_i != ei_q) && (cnt_q == CW'(EI_DEB_CYC - 1));
    assign rise_o = flip_d && !ei_q;
    assign ei_o   = ei_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            ei_q  <= 1'b0;
        end else if (set_i || clr_i) begin
            cnt_q <= '0;
            ei_q  <= set_i;
        end else begin
            cnt_q <= (ei_detect_i == ei_q || flip_d) ? '0 : cnt_q + 1'b1;
            if (flip_d) ei_q <= ei_detect_i;
        end
    end
endmodule

// File: rtl/hplvds_rx_ctrl.sv
// hplvds_rx_ctrl: HPLVDS lane receiver control (power-up, EI handling, word alignment).
// Optional PRBS7 error checker enabled by defining HPLVDS_RX_PRBS_CHK_EN.
module hplvds_rx_ctrl
    import hplvds_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned EI_DEB_CYC = 8,
    parameter logic [7:0]  SYNC_WORD  = SYNC_WORD_DEF,
    parameter int unsigned LOCK_CNT   = 2
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic        ENABLE_I,
    input  logic        POL_I,
    input  logic        DI_I,
    input  logic        EI_DETECT_I,
`ifdef HPLVDS_RX_PRBS_CHK_EN
    input  logic        PRBS_CHK_EN_I,
    input  logic        PRBS_CLR_I,
    output logic [15:0] PRBS_ERR_CNT_O,
`endif
    output logic        RTERM_EN_O,
    output logic        RX_EN_O,
    output logic        EI_DETECT_EN_O,
    output logic        RX_POL_O,
    output logic [7:0]  DATA_O,
    output logic        VALID_O,
    output logic        LOCKED_O,
    output logic        EI_O
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);
    state_e        state_q;
    logic [SW-1:0] settle_q;
    logic [LW-1:0] lock_cnt_q;
    logic [2:0]    wcnt_q;
    logic [7:0]    sr_q, data_q;
    logic          armed_q, pad_en_q, rx_pol_q, valid_q, locked_q;
    logic [7:0]    sr_d;
    logic          match_d, settle_done_d, ei, ei_rise;
    assign sr_d          = {DI_I, sr_q[7:1]};
    assign match_d       = (sr_d == SYNC_WORD);
    assign settle_done_d = ENABLE_I && state_q == SETTLE && settle_q == SW'(SETTLE_CYC - 1);
    hplvds_ei_debounce #(.EI_DEB_CYC(EI_DEB_CYC)) u_ei_deb (
        .clk_i      (CLK_I),
        .rst_n_i    (RST_N_I),
        .clr_i      (!ENABLE_I || state_q == OFF || state_q == SETTLE),
        .set_i      (settle_done_d),
        .ei_detect_i(EI_DETECT_I),
        .ei_o       (ei),
        .rise_o     (ei_rise)
    );
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q    <= OFF;
            settle_q   <= '0;
            lock_cnt_q <= '0;
            wcnt_q     <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            armed_q    <= 1'b0;
            pad_en_q   <= 1'b0;
            rx_pol_q   <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else if (!ENABLE_I) begin
            state_q    <= OFF;
            settle_q   <= '0;
            lock_cnt_q <= '0;
            wcnt_q     <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            armed_q    <= 1'b0;
            pad_en_q   <= 1'b0;
            rx_pol_q   <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                OFF: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                    pad_en_q <= 1'b1;
                    rx_pol_q <= POL_I;
                end
                SETTLE: begin
                    if (settle_done_d) state_q <= IDLE;
                    else settle_q <= settle_q + 1'b1;
                end
                IDLE: begin
                    rx_pol_q <= POL_I;
                    if (!ei) begin
                        state_q    <= HUNT;
                        sr_q       <= '0;
                        lock_cnt_q <= '0;
                        armed_q    <= 1'b0;
                        wcnt_q     <= '0;
                    end
                end
                HUNT: begin
                    sr_q   <= sr_d;
                    wcnt_q <= wcnt_q + 1'b1;
                    if (!armed_q) begin
                        if (match_d) begin
                            armed_q <= 1'b1;
                            wcnt_q  <= '0;
                            if (LOCK_CNT <= 1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else lock_cnt_q <= LW'(1);
                        end
                    end else if (wcnt_q == 3'd7) begin
                        // A miss at the boundary drops back to bit-by-bit search
                        if (!match_d) begin
                            armed_q    <= 1'b0;
                            lock_cnt_q <= '0;
                        end else if (lock_cnt_q == LW'(LOCK_CNT - 1)) begin
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                            lock_cnt_q <= '0;
                        end else lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    sr_q   <= sr_d;
                    wcnt_q <= wcnt_q + 1'b1;
                    if (ei_rise) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                        armed_q  <= 1'b0;
                    end else if (wcnt_q == 3'd7) begin
                        data_q  <= sr_d;
                        valid_q <= 1'b1;
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end
    assign RTERM_EN_O     = pad_en_q;
    assign RX_EN_O        = pad_en_q;
    assign EI_DETECT_EN_O = pad_en_q;
    assign RX_POL_O       = rx_pol_q;
    assign DATA_O         = data_q;
    assign VALID_O        = valid_q;
    assign LOCKED_O       = locked_q;
    assign EI_O           = ei;
`ifdef HPLVDS_RX_PRBS_CHK_EN
    logic [6:0]  prbs_q;
    logic [2:0]  seed_q;
    logic [15:0] err_q;
    logic        chk_on, exp_bit;
    assign chk_on  = PRBS_CHK_EN_I && state_q == LOCKED;
    assign exp_bit = ^(prbs_q & PRBS7_POLY);
    // After seeding the checker free-runs, so a flipped bit counts exactly once
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            prbs_q <= '0;
            seed_q <= '0;
            err_q  <= '0;
        end else begin
            if (!chk_on) begin
                prbs_q <= '0;
                seed_q <= '0;
            end else if (seed_q != 3'd7) begin
                prbs_q <= {prbs_q[5:0], DI_I};
                seed_q <= seed_q + 1'b1;
            end else prbs_q <= {prbs_q[5:0], exp_bit};
            if (PRBS_CLR_I) err_q <= '0;
            else if (chk_on && seed_q == 3'd7 && DI_I != exp_bit && err_q != 16'hFFFF) err_q <= err_q + 1'b1;
        end
    end
    assign PRBS_ERR_CNT_O = err_q;
`endif
endmodule

// File: tb/tb_hplvds_rx_ctrl.sv
// tb_hplvds_rx_ctrl: directed self-checking bench for hplvds_rx_ctrl
// (define HPLVDS_RX_PRBS_CHK_EN to also exercise the PRBS7 checker).
module tb_hplvds_rx_ctrl;
    import hplvds_pkg::*;
    logic        CLK_I = 1'b0, RST_N_I, ENABLE_I, POL_I, DI_I, EI_DETECT_I;
    logic        RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, RX_POL_O, VALID_O, LOCKED_O, EI_O;
    logic [7:0]  DATA_O;
    logic [14:0] outs;
    int          checks = 0, failures = 0, vcnt = 0;
    logic [7:0]  last_data = '0;
`ifdef HPLVDS_RX_PRBS_CHK_EN
    logic        PRBS_CHK_EN_I = 1'b1, PRBS_CLR_I = 1'b0;
    logic [15:0] PRBS_ERR_CNT_O;
    logic [6:0]  t;
    logic        b;
`endif
    always #5 CLK_I = ~CLK_I;
    assign outs = {RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O, RX_POL_O, VALID_O, LOCKED_O, EI_O, DATA_O};
    hplvds_rx_ctrl dut (
        .CLK_I         (CLK_I),
        .RST_N_I       (RST_N_I),
        .ENABLE_I      (ENABLE_I),
        .POL_I         (POL_I),
        .DI_I          (DI_I),
        .EI_DETECT_I   (EI_DETECT_I),
`ifdef HPLVDS_RX_PRBS_CHK_EN
        .PRBS_CHK_EN_I (PRBS_CHK_EN_I),
        .PRBS_CLR_I    (PRBS_CLR_I),
        .PRBS_ERR_CNT_O(PRBS_ERR_CNT_O),
`endif
        .RTERM_EN_O    (RTERM_EN_O),
        .RX_EN_O       (RX_EN_O),
        .EI_DETECT_EN_O(EI_DETECT_EN_O),
        .RX_POL_O      (RX_POL_O),
        .DATA_O        (DATA_O),
        .VALID_O       (VALID_O),
        .LOCKED_O      (LOCKED_O),
        .EI_O          (EI_O)
    );
    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic step();
        @(posedge CLK_I);
        #1;
        if (VALID_O) begin
            vcnt++;
            last_data = DATA_O;
        end
    endtask
    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            DI_I = v[i];
            step();
        end
    endtask
    initial begin
        RST_N_I = 1'b0; ENABLE_I = 1'b0; POL_I = 1'b0; DI_I = 1'b0; EI_DETECT_I = 1'b0;
        step(); step();
        check("rst_outs", 16'(outs), 16'h0);
        check("rst_state", 16'(dut.state_q), 16'(OFF));
        RST_N_I = 1'b1;
        step();
        check("off_outs", 16'(outs), 16'h0);
        ENABLE_I = 1'b1; POL_I = 1'b1; EI_DETECT_I = 1'b1;
        step();
        check("pads_c1", 16'({RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O}), 16'h7);
        check("pol_c1", 16'(RX_POL_O), 16'h1);
        check("settle_c1", 16'(dut.state_q), 16'(SETTLE));
        POL_I = 1'b0;
        repeat (63) step();
        check("settle_c64", 16'(dut.state_q), 16'(SETTLE));
        check("pol_hold", 16'(RX_POL_O), 16'h1);
        step();
        check("idle_c65", 16'(dut.state_q), 16'(IDLE));
        check("ei_set", 16'(EI_O), 16'h1);
        step();
        check("pol_idle", 16'(RX_POL_O), 16'h0);
        EI_DETECT_I = 1'b0;
        repeat (7) step();
        check("ei_deb7", 16'(EI_O), 16'h1);
        step();
        check("ei_deb8", 16'(EI_O), 16'h0);
        step();
        check("hunt", 16'(dut.state_q), 16'(HUNT));
        send_byte(8'hBC);
        check("lock_1st", 16'(LOCKED_O), 16'h0);
        send_byte(8'hBC);
        check("lock_2nd", 16'(LOCKED_O), 16'h1);
        check("st_locked", 16'(dut.state_q), 16'(LOCKED));
        vcnt = 0;
        send_byte(8'h5A);
        check("valid_5a", 16'(VALID_O), 16'h1);
        check("data_5a", 16'(last_data), 16'h5A);
        check("vcnt_5a", 16'(vcnt), 16'h1);
        vcnt = 0; DI_I = 1'b0; EI_DETECT_I = 1'b1;
        repeat (7) step();
        EI_DETECT_I = 1'b0;
        step();
        check("glitch_st", 16'(dut.state_q), 16'(LOCKED));
        check("glitch_ei", 16'(EI_O), 16'h0);
        check("glitch_vcnt", 16'(vcnt), 16'h1);
        check("glitch_data", 16'(last_data), 16'h00);
        vcnt = 0; EI_DETECT_I = 1'b1;
        repeat (8) step();
        check("ei_exit_st", 16'(dut.state_q), 16'(IDLE));
        check("ei_exit_lock", 16'(LOCKED_O), 16'h0);
        check("ei_exit_ei", 16'(EI_O), 16'h1);
        check("ei_suppress", 16'(vcnt), 16'h0);
        EI_DETECT_I = 1'b0;
        repeat (9) step();
        check("hunt2", 16'(dut.state_q), 16'(HUNT));
        send_byte(8'hBC);
        send_byte(8'h3C);
        check("miss_st", 16'(dut.state_q), 16'(HUNT));
        check("miss_cnt", 16'(dut.lock_cnt_q), 16'h0);
        check("miss_lock", 16'(LOCKED_O), 16'h0);
        DI_I = 1'b1; step();
        DI_I = 1'b0; step();
        DI_I = 1'b1; step();
        send_byte(8'hBC);
        check("off3_1st", 16'(LOCKED_O), 16'h0);
`ifdef HPLVDS_RX_PRBS_CHK_EN
        PRBS_CLR_I = 1'b1;
`endif
        send_byte(8'hBC);
        check("off3_lock", 16'(LOCKED_O), 16'h1);
`ifdef HPLVDS_RX_PRBS_CHK_EN
        PRBS_CLR_I = 1'b0;
        t = 7'h7F;
        for (int i = 0; i < 57; i++) begin
            b = t[6] ^ t[5];
            t = {t[5:0], b};
            DI_I = b ^ (i == 10 || i == 20 || i == 30);
            step();
        end
        check("prbs_err3", PRBS_ERR_CNT_O, 16'd3);
        PRBS_CLR_I = 1'b1;
        step();
        PRBS_CLR_I = 1'b0;
        check("prbs_clr", PRBS_ERR_CNT_O, 16'd0);
`endif
        DI_I = 1'b1;
        repeat (3) step();
        ENABLE_I = 1'b0;
        step();
        check("dis_st", 16'(dut.state_q), 16'(OFF));
        check("dis_outs", 16'(outs), 16'h0);
        check("dis_cnt", 16'({dut.lock_cnt_q, dut.wcnt_q}), 16'h0);
        ENABLE_I = 1'b1;
        repeat (10) step();
        check("settle_mid", 16'(dut.state_q), 16'(SETTLE));
        #2 RST_N_I = 1'b0;
        #1;
        check("arst_st", 16'(dut.state_q), 16'(OFF));
        check("arst_outs", 16'(outs), 16'h0);
        check("arst_settle", 16'(dut.settle_q), 16'h0);
        RST_N_I = 1'b1;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hplvds_rx_ctrl.md
HPLVDS_RX_CTRL -- requirements
Module: hplvds_rx_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 64: cycles after enable before the receiver output is trusted.
REQ-002 Parameter EI_DEB_CYC, default 8: consecutive cycles an electrical-idle level must be stable before it is acted on.
REQ-003 Parameter SYNC_WORD, default 8'hBC: alignment word.
REQ-004 Parameter LOCK_CNT, default 2: consecutive aligned SYNC_WORDs required to declare lock.
REQ-005 CLK_I  in  1  bit-rate sampling clock, the only clock.
REQ-006 RST_N_I  in  1  asynchronous, active-low reset.
REQ-007 ENABLE_I  in  1  lane enable.
REQ-008 POL_I  in  1  lane polarity inversion request.
REQ-009 DI_I  in  1  serial data from the pad receiver.
REQ-010 EI_DETECT_I  in  1  electrical-idle flag from the pad.
REQ-011 RTERM_EN_O, RX_EN_O, EI_DETECT_EN_O  out  1 each  pad enables.
REQ-012 RX_POL_O  out  1  pad polarity.
REQ-013 DATA_O  out  8  deserialized byte, first received bit in bit 0.
REQ-014 VALID_O  out  1  one-cycle strobe qualifying DATA_O.
REQ-015 LOCKED_O  out  1  word alignment achieved.
REQ-016 EI_O  out  1  debounced electrical idle.

Function
REQ-017 The FSM states SHALL be OFF, SETTLE, IDLE, HUNT and LOCKED.
REQ-018 OFF: all outputs 0; ENABLE_I=1 -> SETTLE next cycle, settle counter cleared.
REQ-019 SETTLE: RTERM_EN_O=RX_EN_O=EI_DETECT_EN_O=1; after exactly SETTLE_CYC cycles -> IDLE.
REQ-020 The pad enables SHALL remain 1 in IDLE, HUNT and LOCKED.
REQ-021 RX_POL_O SHALL register POL_I and SHALL only update in OFF or IDLE.
REQ-022 EI_O SHALL change only after EI_DETECT_I holds the opposite value for EI_DEB_CYC consecutive cycles; any toggle restarts the count.
REQ-023 EI_O SHALL be set to 1 on entry to IDLE from SETTLE.
REQ-024 IDLE: EI_O falling -> HUNT with the shift register and lock counter cleared.
REQ-025 HUNT: an 8-bit shift register shifts in DI_I each cycle, LSB-first.
REQ-026 HUNT: a SYNC_WORD match starts an 8-cycle word counter; each further match exactly 8 cycles later increments the lock counter; a non-match at the 8-cycle boundary clears the count and restarts the search bit-by-bit.
REQ-027 HUNT: the LOCK_CNT-th consecutive match -> LOCKED; LOCKED_O=1 in the same cycle.
REQ-028 LOCKED: at every 8-cycle boundary, DATA_O is loaded and VALID_O pulses for 1 cycle; the latency from the last bit sampled to VALID_O is 1 cycle.
REQ-029 LOCKED: EI_O rising -> IDLE, LOCKED_O=0 and no further VALID_O.
REQ-030 ENABLE_I=0 in any state -> OFF next cycle, clearing all counters and VALID_O; this has priority over all other transitions.
REQ-031 A simultaneous EI_O rise and word boundary SHALL suppress that VALID_O.
REQ-032 All counters SHALL saturate or reset without wrap-around errors; the settle counter SHALL be sized clog2(SETTLE_CYC+1).

Reset
REQ-033 RST_N_I low SHALL force state OFF and set every output, counter and shift register to 0 asynchronously; release is synchronous to CLK_I.

Configuration
REQ-034 With macro HPLVDS_RX_PRBS_CHK_EN defined, ports PRBS_CHK_EN_I (in 1), PRBS_ERR_CNT_O (out 16) and PRBS_CLR_I (in 1) SHALL exist.
REQ-035 With HPLVDS_RX_PRBS_CHK_EN defined, a PRBS7 checker (x^7+x^6+1) SHALL self-seed from the first 7 bits received in LOCKED, then count per-bit mismatches, saturating at 16'hFFFF; PRBS_CLR_I zeroes the count.
REQ-036 Without HPLVDS_RX_PRBS_CHK_EN, none of these ports or logic SHALL exist.

Structure
REQ-037 The FSM state enum, SYNC_WORD default and PRBS7 polynomial constant SHALL reside in shared package hplvds_pkg.
REQ-038 The debounce SHALL be a sub-module hplvds_ei_debounce (parameter EI_DEB_CYC), instanced once.

Verification
REQ-039 Reset, ENABLE_I=1 -> pad enables =1 at cycle 1, state IDLE at cycle 65, EI_O=1.
REQ-040 EI_DETECT_I=0 for 8 cycles, then stream 0xBC,0xBC,0x5A LSB-first -> LOCKED_O=1 after 2nd 0xBC; DATA_O=0x5A with a single VALID_O pulse.
REQ-041 EI_DETECT_I glitch high for 7 cycles in LOCKED -> no exit; held 8 cycles -> IDLE, LOCKED_O=0.
REQ-042 0xBC then 0x3C at the next boundary -> remains HUNT, lock count 0; stream offset by 3 bits still locks.
REQ-043 ENABLE_I=0 mid-byte in LOCKED -> OFF next cycle, all outputs 0; RST_N_I pulsed mid-SETTLE -> immediate OFF.
REQ-044 With HPLVDS_RX_PRBS_CHK_EN, PRBS7 stream with 3 injected bit flips -> PRBS_ERR_CNT_O=3; PRBS_CLR_I -> 0.
